// File: rtl/fetch_line_buffer_pkg.sv
// Shared widths, FSM encoding and helpers for the fetch line buffer.
// Imported by the line entry and the top level.
package fetch_line_buffer_pkg;

    localparam int LINE_W         = 256;
    localparam int WORD_W         = 16;
    localparam int WORDS_PER_LINE = 16;
    localparam int TAG_W          = 12;
    localparam int WSEL_W         = $clog2(WORDS_PER_LINE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        D_WAIT = 2'd1,
        P_WAIT = 2'd2
    } fstate_t;

    function automatic logic [15:0] line_addr(
        input logic [TAG_W-1:0] t
    );
        return {{(16-TAG_W){1'b0}}, t};
    endfunction

endpackage

// File: rtl/fetch_line_entry.sv
// One buffered cache line: valid/tag/data registers,
// tag compare and word select.
module fetch_line_entry
    import fetch_line_buffer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [TAG_W-1:0]  load_tag,
    input  logic [LINE_W-1:0] load_data,
    input  logic [TAG_W-1:0]  tag,
    input  logic [WSEL_W-1:0] word_sel,
    output logic              hit,
    output logic [WORD_W-1:0] word
);

    logic              valid;
    logic [TAG_W-1:0]  tag_q;
    logic [LINE_W-1:0] data_q;

    // clear beats load so an invalidate always wins over a fill
    always_ff @(posedge clk) begin
        if (reset) begin
            valid  <= 1'b0;
            tag_q  <= '0;
            data_q <= '0;
        end else if (clear) begin
            valid  <= 1'b0;
        end else if (load) begin
            valid  <= 1'b1;
            tag_q  <= load_tag;
            data_q <= load_data;
        end
    end

    assign hit  = valid && (tag_q == tag);
    assign word = data_q[word_sel*WORD_W +: WORD_W];

endmodule

// File: rtl/fetch_line_buffer.sv
// Two-line fetch buffer in front of fcache: zero-latency hits,
// demand fills on miss, sequential prefetch into the next entry.
module fetch_line_buffer
    import fetch_line_buffer_pkg::*;
#(
    parameter int RD_LAT   = 1,
    parameter bit PREFETCH = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       pc,
    input  logic              pc_valid,
    input  logic              inval,
    output logic [15:0]       instr,
    output logic              instr_valid,
    output logic              stall,
    output logic              cache_read,
    output logic [15:0]       cache_addr,
    input  logic [LINE_W-1:0] cache_rdata
);

    localparam int CNT_W = $clog2(RD_LAT + 1);

    fstate_t           state;
    logic [CNT_W-1:0]  cnt;
    logic              stale;
    logic              dem;
    logic              sel;
    logic [TAG_W-1:0]  req_tag;

    logic [TAG_W-1:0]  tag;
    logic [WSEL_W-1:0] wsel;
    logic [1:0]        ehit;
    logic [WORD_W-1:0] eword [2];
    logic [1:0]        eload;
    logic [1:0]        eclear;

    logic cur_hit, nxt_hit, hit, miss;
    logic promote, shift, done, good;
    logic dem_match, to_cur, cap_cur, cap_nxt, dst;

    assign tag        = pc[15:4];
    assign wsel       = pc[3:0];
    assign cache_addr = line_addr(req_tag);

    // CUR/NXT roles are a pointer: promotion just flips sel
    for (genvar i = 0; i < 2; i++) begin : g_ent
        fetch_line_entry u_ent (
            .clk       (clk),
            .reset     (reset),
            .load      (eload[i]),
            .clear     (eclear[i]),
            .load_tag  (req_tag),
            .load_data (cache_rdata),
            .tag       (tag),
            .word_sel  (wsel),
            .hit       (ehit[i]),
            .word      (eword[i])
        );
    end

    assign cur_hit     = ehit[sel];
    assign nxt_hit     = ehit[~sel];
    assign hit         = !inval && (cur_hit || nxt_hit);
    assign instr_valid = pc_valid && hit;
    assign stall       = pc_valid && !hit;
    assign miss        = pc_valid && !hit;
    assign instr       = !instr_valid ? '0 :
                         cur_hit ? eword[sel] : eword[~sel];

    assign promote   = instr_valid && !cur_hit;
    assign done      = (state != IDLE) &&
                       (cnt == CNT_W'(RD_LAT));
    assign good      = done && !stale && !inval;
    assign dem_match = (state == P_WAIT) && miss &&
                       (tag == req_tag);
    assign to_cur    = (state == D_WAIT) || dem || dem_match;
    assign cap_cur   = good && to_cur;
    assign cap_nxt   = good && !to_cur;
    assign shift     = promote && !cap_cur;
    assign dst       = (cap_cur || shift) ? sel : ~sel;

    always_comb begin
        eload  = '0;
        eclear = {2{inval}};
        if (cap_cur || cap_nxt)
            eload[dst] = 1'b1;
        if (shift && !cap_nxt)
            eclear[sel] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            stale      <= 1'b0;
            dem        <= 1'b0;
            sel        <= 1'b0;
            cache_read <= 1'b0;
            req_tag    <= '0;
        end else begin
            cache_read <= 1'b0;
            if (shift)
                sel <= ~sel;
            unique case (state)
                IDLE: begin
                    if (shift && PREFETCH) begin
                        cache_read <= 1'b1;
                        req_tag    <= tag + TAG_W'(1);
                        cnt        <= '0;
                        stale      <= 1'b0;
                        dem        <= 1'b0;
                        state      <= P_WAIT;
                    end else if (miss) begin
                        cache_read <= 1'b1;
                        req_tag    <= tag;
                        cnt        <= '0;
                        stale      <= 1'b0;
                        dem        <= 1'b0;
                        state      <= D_WAIT;
                    end
                end
                D_WAIT: begin
                    if (done) begin
                        stale <= 1'b0;
                        if (!good || !PREFETCH) begin
                            state <= IDLE;
                        end else begin
                            cache_read <= 1'b1;
                            req_tag    <= req_tag + TAG_W'(1);
                            cnt        <= '0;
                            dem        <= 1'b0;
                            state      <= P_WAIT;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (inval)
                            stale <= 1'b1;
                    end
                end
                P_WAIT: begin
                    if (done) begin
                        stale <= 1'b0;
                        dem   <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (inval)
                            stale <= 1'b1;
                        if (dem_match)
                            dem <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_line_buffer.sv
// Scoreboard bench for fetch_line_buffer with an RD_LAT=1 fcache model.
// Line L word i holds {L[11:0], i[3:0]}, i.e. the word address itself.
module tb_fetch_line_buffer;

    logic         clk = 1'b0;
    logic         reset;
    logic [15:0]  pc;
    logic         pc_valid;
    logic         inval;
    logic [15:0]  instr;
    logic         instr_valid;
    logic         stall;
    logic         cache_read;
    logic [15:0]  cache_addr;
    logic [255:0] cache_rdata = '0;

    int n_chk  = 0;
    int n_fail = 0;
    int w;

    logic [15:0] exp_q [$];
    logic [15:0] addr_q [$];

    always #5 clk = ~clk;

    fetch_line_buffer #(
        .RD_LAT   (1),
        .PREFETCH (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .pc_valid    (pc_valid),
        .inval       (inval),
        .instr       (instr),
        .instr_valid (instr_valid),
        .stall       (stall),
        .cache_read  (cache_read),
        .cache_addr  (cache_addr),
        .cache_rdata (cache_rdata)
    );

    function automatic logic [255:0] line_of(input logic [11:0] l);
        logic [255:0] d;
        d = '0;
        for (int i = 0; i < 16; i++)
            d[16*i +: 16] = {l, 4'(i)};
        return d;
    endfunction

    always @(posedge clk)
        if (cache_read)
            cache_rdata <= line_of(cache_addr[11:0]);

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && cache_read) begin
            if (addr_q.size() == 0)
                check("rd_extra", 32'(addr_q.size()), 1);
            else
                check("cache_addr", 32'(cache_addr),
                      32'(addr_q.pop_front()));
        end
    end

    task automatic fetch(
        input  logic [15:0] a,
        input  int          max_wait,
        output int          waited
    );
        logic [15:0] e;
        bit got;
        pc       = a;
        pc_valid = 1'b1;
        exp_q.push_back(a);
        waited = 0;
        got    = 1'b0;
        while (!got && waited <= max_wait) begin
            @(negedge clk);
            if (instr_valid) begin
                e = exp_q.pop_front();
                check($sformatf("instr@%h", a),
                      32'(instr), 32'(e));
                got = 1'b1;
            end else begin
                waited++;
            end
        end
        if (!got) begin
            void'(exp_q.pop_front());
            check("fetch_timeout", 32'(got), 1);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        pc_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit hit");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        pc       = '0;
        pc_valid = 1'b0;
        inval    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_read", 32'(cache_read), 0);
        check("rst_addr", 32'(cache_addr), 0);
        check("rst_valid", 32'(instr_valid), 0);
        check("rst_instr", 32'(instr), 0);
        check("rst_stall", 32'(stall), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // cold miss, then sequential walk across a line edge
        addr_q.push_back(16'h0012);
        addr_q.push_back(16'h0013);
        addr_q.push_back(16'h0014);
        fetch(16'h0123, 16, w);
        check("t1_cold_stall", 32'(w), 3);
        for (int a = 16'h0124; a <= 16'h0130; a++) begin
            fetch(16'(a), 4, w);
            check($sformatf("t2_nostall@%h", a), 32'(w), 0);
        end

        // top line, prefetch wraps to line 0
        addr_q.push_back(16'h0FFF);
        addr_q.push_back(16'h0000);
        fetch(16'hFFF5, 16, w);
        idle(3);
        addr_q.push_back(16'h0001);
        fetch(16'h0002, 4, w);
        check("t3_wrap_nostall", 32'(w), 0);

        // demand miss on the line already being prefetched
        addr_q.push_back(16'h003F);
        addr_q.push_back(16'h0040);
        fetch(16'h03F0, 16, w);
        fetch(16'h0400, 4, w);
        check("t4_pf_merge_stall", 32'(w), 1);

        // inval forces a miss on a resident line
        addr_q.push_back(16'h0040);
        addr_q.push_back(16'h0041);
        pc       = 16'h0401;
        pc_valid = 1'b1;
        inval    = 1'b1;
        @(negedge clk);
        check("inval_hit_valid", 32'(instr_valid), 0);
        check("inval_hit_stall", 32'(stall), 1);
        @(posedge clk); #1;
        inval = 1'b0;
        fetch(16'h0401, 8, w);
        idle(4);

        // inval during D_WAIT discards the fill
        addr_q.push_back(16'h0050);
        pc       = 16'h0500;
        pc_valid = 1'b1;
        @(negedge clk);
        check("t5_stall", 32'(stall), 1);
        @(posedge clk); #1;
        inval = 1'b1;
        @(negedge clk);
        check("t5_inval_valid", 32'(instr_valid), 0);
        @(posedge clk); #1;
        inval = 1'b0;
        @(negedge clk);
        check("t5_land_valid", 32'(instr_valid), 0);
        @(posedge clk); #1;
        addr_q.push_back(16'h0050);
        addr_q.push_back(16'h0051);
        @(negedge clk);
        check("t5_discard_valid", 32'(instr_valid), 0);
        @(posedge clk); #1;
        fetch(16'h0500, 8, w);
        idle(4);

        // reset in the middle of a fill
        addr_q.push_back(16'h0060);
        pc       = 16'h0600;
        pc_valid = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("t6_strobe", 32'(cache_read), 1);
        @(posedge clk); #1;
        reset    = 1'b1;
        pc_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("t6_rst_read", 32'(cache_read), 0);
        check("t6_rst_addr", 32'(cache_addr), 0);
        check("t6_rst_valid", 32'(instr_valid), 0);
        check("t6_rst_stall", 32'(stall), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        addr_q.push_back(16'h0060);
        addr_q.push_back(16'h0061);
        pc       = 16'h0600;
        pc_valid = 1'b1;
        @(negedge clk);
        check("t6_late_rdata", 32'(instr_valid), 0);
        @(posedge clk); #1;
        fetch(16'h0600, 8, w);
        idle(4);

        check("rd_q_empty", 32'(addr_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
